// File: rtl/loteria_pkg.sv
// Shared types and constants for the lottery bet datapath.
// Holds the sequencer state enum, the BCD digit width and limit, and the
// width of the 5-bit counters shared with the prize outputs.
package loteria_pkg;

    localparam int DIGITO_W   = 4;
    localparam int CONTADOR_W = 5;

    localparam logic [DIGITO_W-1:0]   DIGITO_MAX   = 4'd9;
    localparam logic [CONTADOR_W-1:0] CONTADOR_MAX = '1;

    typedef enum logic [2:0] {
        COLETA,
        ENVIA,
        ESPERA,
        FECHA,
        FIM
    } estado_t;

endpackage

// File: rtl/aposta_buffer.sv
// Bet digit register file: NUM_DIGITOS x 4-bit entries with a write pointer.
// A write lands at the current pointer and advances it; limpa only rewinds
// the pointer, while reset also zeroes every stored digit.
module aposta_buffer
    import loteria_pkg::*;
#(
    parameter int NUM_DIGITOS = 5
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 escreve,
    input  logic [DIGITO_W-1:0]                  dado,
    input  logic                                 limpa,
    output logic [NUM_DIGITOS-1:0][DIGITO_W-1:0] digitos,
    output logic [2:0]                           qtd
);

    localparam logic [2:0] CAPACIDADE = 3'(NUM_DIGITOS);

    logic [NUM_DIGITOS-1:0][DIGITO_W-1:0] mem_q, mem_d;
    logic [2:0]                           ptr_q, ptr_d;

    // Next buffer contents: clear wins, writes are dropped once full.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        if (limpa) begin
            ptr_d = '0;
        end else if (escreve && (ptr_q < CAPACIDADE)) begin
            mem_d[ptr_q] = dado;
            ptr_d        = ptr_q + 3'd1;
        end
    end

    // Register the digits and the write pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q <= '0;
            ptr_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
        end
    end

    assign digitos = mem_q;
    assign qtd     = ptr_q;

endmodule

// File: rtl/aposta_sequenciador.sv
// Bet sequencer: collects BCD digits from a keypad, then replays the bet to
// the downstream checker as insere strobes spaced by GAP_CICLOS idle cycles,
// adds a closing strobe repeating the last digit, and ends with fim_jogo.
// Optional feature macro: APOSTA_CONTADOR_EN adds the saturating apostas
// counter output.
// Handshake: insere, fim_jogo and erro are single-cycle strobes with no
// back-pressure; inputs are only honoured while ocupado is low.
// estado exposes the current FSM state for debug.
module aposta_sequenciador
    import loteria_pkg::*;
#(
    parameter int NUM_DIGITOS = 5,
    parameter int GAP_CICLOS  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DIGITO_W-1:0]   digito_in,
    input  logic                  digito_valido,
    input  logic                  apaga,
    input  logic                  confirma,
    output logic [DIGITO_W-1:0]   numero,
    output logic                  insere,
    output logic                  fim_jogo,
    output logic                  ocupado,
    output logic                  erro,
    output logic [2:0]            qtd_digitos,
    output estado_t               estado
`ifdef APOSTA_CONTADOR_EN
    ,
    output logic [CONTADOR_W-1:0] apostas
`endif
);

    localparam logic [2:0] TOTAL    = 3'(NUM_DIGITOS);
    localparam logic [1:0] GAP_ULT  = 2'(GAP_CICLOS - 1);
    localparam bit         SEM_GAP  = (GAP_CICLOS == 0);

    estado_t               state_q, state_d;
    logic [2:0]            idx_q, idx_d, idx_prox;
    logic [1:0]            espera_q, espera_d;
    logic [DIGITO_W-1:0]   numero_q, numero_d;
    logic                  insere_q, insere_d;
    logic                  fim_q, fim_d;
    logic                  ocupado_q, ocupado_d;
    logic                  erro_q, erro_d;
    logic                  avancar;
    logic                  buf_escreve, buf_limpa;
    logic [NUM_DIGITOS-1:0][DIGITO_W-1:0] digitos;

    aposta_buffer #(
        .NUM_DIGITOS (NUM_DIGITOS)
    ) u_buffer (
        .clock   (clock),
        .reset   (reset),
        .escreve (buf_escreve),
        .dado    (digito_in),
        .limpa   (buf_limpa),
        .digitos (digitos),
        .qtd     (qtd_digitos)
    );

    // Next state and next registered outputs. idx == NUM_DIGITOS marks the
    // closing strobe, so an expiring wait there leads to FIM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        espera_d    = espera_q;
        numero_d    = numero_q;
        erro_d      = 1'b0;
        avancar     = 1'b0;
        buf_escreve = 1'b0;
        buf_limpa   = 1'b0;
        idx_prox    = idx_q + 3'd1;

        case (state_q)
            COLETA: begin
                if (apaga) begin
                    buf_limpa = 1'b1;
                end else if (digito_valido) begin
                    if ((digito_in > DIGITO_MAX) || (qtd_digitos == TOTAL)) begin
                        erro_d = 1'b1;
                    end else begin
                        buf_escreve = 1'b1;
                    end
                end else if (confirma) begin
                    if (qtd_digitos == TOTAL) begin
                        state_d = ENVIA;
                        idx_d   = '0;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            ENVIA, FECHA: begin
                if (SEM_GAP) begin
                    avancar = 1'b1;
                end else begin
                    state_d  = ESPERA;
                    espera_d = '0;
                end
            end
            ESPERA: begin
                if (espera_q == GAP_ULT) begin
                    avancar = 1'b1;
                end else begin
                    espera_d = espera_q + 2'd1;
                end
            end
            FIM: begin
                state_d   = COLETA;
                buf_limpa = 1'b1;
            end
            default: begin
                state_d = COLETA;
            end
        endcase

        if (avancar) begin
            if (idx_q == TOTAL) begin
                state_d = FIM;
            end else begin
                idx_d   = idx_prox;
                state_d = (idx_prox == TOTAL) ? FECHA : ENVIA;
            end
        end

        insere_d  = (state_d == ENVIA) || (state_d == FECHA);
        fim_d     = (state_d == FIM);
        ocupado_d = (state_d != COLETA);
        case (state_d)
            COLETA:      numero_d = '0;
            ENVIA:       numero_d = digitos[idx_d];
            FECHA, FIM:  numero_d = digitos[NUM_DIGITOS-1];
            default:     numero_d = numero_q;
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= COLETA;
            idx_q     <= '0;
            espera_q  <= '0;
            numero_q  <= '0;
            insere_q  <= 1'b0;
            fim_q     <= 1'b0;
            ocupado_q <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            espera_q  <= espera_d;
            numero_q  <= numero_d;
            insere_q  <= insere_d;
            fim_q     <= fim_d;
            ocupado_q <= ocupado_d;
            erro_q    <= erro_d;
        end
    end

    assign numero   = numero_q;
    assign insere   = insere_q;
    assign fim_jogo = fim_q;
    assign ocupado  = ocupado_q;
    assign erro     = erro_q;
    assign estado   = state_q;

`ifdef APOSTA_CONTADOR_EN
    logic [CONTADOR_W-1:0] apostas_q, apostas_d;

    // Count completed bets, saturating at the counter maximum.
    always_comb begin
        apostas_d = apostas_q;
        if ((state_d == FIM) && (apostas_q != CONTADOR_MAX)) begin
            apostas_d = apostas_q + 1'b1;
        end
    end

    // Register the bet counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            apostas_q <= '0;
        end else begin
            apostas_q <= apostas_d;
        end
    end

    assign apostas = apostas_q;
`endif

endmodule

// File: tb/tb_aposta_sequenciador.sv
// Bench for aposta_sequenciador: directed scenarios plus random keypad
// traffic, checked every cycle against a behavioural bet/schedule model.
module tb_aposta_sequenciador;
    import loteria_pkg::*;

    localparam int N = 5;
    localparam int G = 1;

    typedef struct packed {
        logic       ins;
        logic       fim;
        logic       err;
        logic       ocu;
        logic [3:0] num;
        logic [2:0] qtd;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digito_in = '0;
    logic       digito_valido = 1'b0;
    logic       apaga = 1'b0;
    logic       confirma = 1'b0;
    logic [3:0] numero;
    logic       insere, fim_jogo, ocupado, erro;
    logic [2:0] qtd_digitos;
    estado_t    estado;
`ifdef APOSTA_CONTADOR_EN
    logic [4:0] apostas;
`endif

    // Clock
    always #5 clock = ~clock;

    aposta_sequenciador #(
        .NUM_DIGITOS (N),
        .GAP_CICLOS  (G)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .digito_in     (digito_in),
        .digito_valido (digito_valido),
        .apaga         (apaga),
        .confirma      (confirma),
        .numero        (numero),
        .insere        (insere),
        .fim_jogo      (fim_jogo),
        .ocupado       (ocupado),
        .erro          (erro),
        .qtd_digitos   (qtd_digitos),
        .estado        (estado)
`ifdef APOSTA_CONTADOR_EN
        ,
        .apostas       (apostas)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    int   bet[$];
    exp_t exp_q[$];
    int   m_apostas = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for every cycle of a send, straight from the timing
    // rule: strobe k at cycle 1+k*(G+1), fim_jogo at 1+(N+1)*(G+1), then idle.
    function automatic void agendar();
        int   per  = G + 1;
        int   jend = 1 + (N + 1) * per;
        exp_t r;
        for (int j = 1; j <= jend; j++) begin
            int k = (j - 1) / per;
            int m = (j - 1) % per;
            r     = '0;
            r.ocu = 1'b1;
            r.qtd = 3'(N);
            if (j == jend) begin
                r.fim = 1'b1;
                r.num = 4'(bet[N-1]);
            end else begin
                r.num = 4'(bet[(k < N) ? k : N - 1]);
                r.ins = (m == 0);
            end
            exp_q.push_back(r);
        end
        r = '0;
        exp_q.push_back(r);
    endfunction

    // Drive one cycle of inputs, advance the model, and compare after the edge.
    task automatic tick(input bit rst, input bit dv, input int din, input bit ap, input bit cf);
        exp_t e;
        reset         = rst;
        digito_valido = dv;
        digito_in     = 4'(din);
        apaga         = ap;
        confirma      = cf;
        e = '0;
        if (rst) begin
            bet.delete();
            exp_q.delete();
            m_apostas = 0;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.fim && m_apostas < 31) m_apostas++;
            if (exp_q.size() == 0) bet.delete();
        end else begin
            if (ap) begin
                bet.delete();
            end else if (dv) begin
                if (din > 9 || bet.size() == N) e.err = 1'b1;
                else bet.push_back(din);
            end else if (cf) begin
                if (bet.size() == N) begin
                    agendar();
                    e = exp_q.pop_front();
                end else begin
                    e.err = 1'b1;
                end
            end
            e.qtd = 3'(bet.size());
        end
        @(posedge clock);
        #1;
        check("insere", insere, e.ins);
        check("fim_jogo", fim_jogo, e.fim);
        check("erro", erro, e.err);
        check("ocupado", ocupado, e.ocu);
        check("numero", numero, e.num);
        check("qtd_digitos", qtd_digitos, e.qtd);
        if (!e.ocu) check("estado", estado, COLETA);
`ifdef APOSTA_CONTADOR_EN
        check("apostas", apostas, m_apostas);
`endif
    endtask

    task automatic ocioso(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    task automatic digitar(input int d);
        tick(0, 1, d, 0, 0);
    endtask

    task automatic drenar();
        int budget = 100;
        while (exp_q.size() > 0 && budget > 0) begin
            tick(0, 0, 0, 0, 0);
            budget--;
        end
        check("drain_budget", exp_q.size(), 0);
    endtask

    initial begin
        int seq_a[5];
        seq_a = '{5, 3, 8, 2, 0};

        // Reset
        tick(1, 0, 0, 0, 0);
        tick(1, 1, 3, 1, 1);
        ocioso(2);

        // Basic bet 5,3,8,2,0 with gaps between keypresses
        foreach (seq_a[i]) begin
            digitar(seq_a[i]);
            ocioso(1);
        end
        tick(0, 0, 0, 0, 1);
        drenar();
        ocioso(2);

        // Out-of-range digit and overflow of a full buffer
        digitar(12);
        for (int i = 1; i <= 5; i++) digitar(i);
        digitar(7);
        digitar(15);
        tick(0, 0, 0, 0, 1);
        drenar();

        // Short confirm rejected, apaga priority, then a normal send
        for (int i = 0; i < 3; i++) digitar(9 - i);
        tick(0, 0, 0, 0, 1);
        tick(0, 1, 4, 1, 1);
        for (int i = 0; i < 5; i++) digitar(i + 4);
        tick(0, 1, 9, 0, 1);
        tick(0, 0, 0, 0, 1);
        drenar();

        // Keypad noise during a send is ignored
        for (int i = 0; i < 5; i++) digitar($urandom_range(0, 9));
        tick(0, 0, 0, 0, 1);
        while (exp_q.size() > 0)
            tick(0, $urandom_range(0, 1), $urandom_range(0, 15),
                 $urandom_range(0, 1), $urandom_range(0, 1));
        ocioso(1);

        // Reset in the middle of a send
        for (int i = 0; i < 5; i++) digitar($urandom_range(0, 9));
        tick(0, 0, 0, 0, 1);
        ocioso(5);
        tick(1, 0, 0, 0, 0);
        ocioso(20);

        // Random traffic
        for (int i = 0; i < 1500; i++)
            tick(0, $urandom_range(0, 2) == 0, $urandom_range(0, 11),
                 $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0);
        drenar();

`ifdef APOSTA_CONTADOR_EN
        // Counter saturation over 33 bets
        tick(1, 0, 0, 0, 0);
        for (int b = 0; b < 33; b++) begin
            for (int i = 0; i < 5; i++) digitar($urandom_range(0, 9));
            tick(0, 0, 0, 0, 1);
            drenar();
        end
        check("apostas_sat", apostas, 31);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aposta_sequenciador.md
APOSTA_SEQUENCIADOR -- requirements
Module: aposta_sequenciador

Interface
REQ-001 The block SHALL have parameter NUM_DIGITOS, default 5, giving the bet length in digits (range 2..7).
REQ-002 The block SHALL have parameter GAP_CICLOS, default 1, giving the idle cycles between output strobes (range 0..3).
REQ-003 The block SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port digito_in, input, 4, the BCD digit from the keypad.
REQ-006 The block SHALL have port digito_valido, input, 1, a one-cycle strobe qualifying digito_in.
REQ-007 The block SHALL have port apaga, input, 1, which clears the partially entered bet.
REQ-008 The block SHALL have port confirma, input, 1, which submits the bet.
REQ-009 The block SHALL have port numero, output, 4, the digit presented to the downstream checker.
REQ-010 The block SHALL have port insere, output, 1, a one-cycle strobe qualifying numero.
REQ-011 The block SHALL have port fim_jogo, output, 1, a one-cycle end-of-bet strobe.
REQ-012 The block SHALL have port ocupado, output, 1, which is high while a bet is being sent.
REQ-013 The block SHALL have port erro, output, 1, a one-cycle rejected-input strobe.
REQ-014 The block SHALL have port qtd_digitos, output, 3, the number of digits currently buffered.

Function
REQ-015 The block SHALL implement states COLETA, ENVIA, ESPERA, FECHA and FIM.
REQ-016 In COLETA, digito_valido with digito_in<=9 and qtd_digitos<NUM_DIGITOS SHALL store the digit at index qtd_digitos and increment qtd_digitos on the next edge.
REQ-017 In COLETA, digito_valido with digito_in>9, or with qtd_digitos==NUM_DIGITOS, SHALL leave the buffer unchanged and pulse erro for 1 cycle.
REQ-018 In COLETA, apaga SHALL set qtd_digitos to 0; apaga SHALL take priority over a simultaneous digito_valido or confirma.
REQ-019 In COLETA, if digito_valido and confirma occur together, the digit SHALL be processed and confirma SHALL be ignored with no erro.
REQ-020 In COLETA, confirma with qtd_digitos==NUM_DIGITOS SHALL enter ENVIA with index 0; confirma with fewer digits SHALL pulse erro and stay in COLETA.
REQ-021 In ENVIA, the block SHALL drive numero=buf[index] and insere=1 for exactly one cycle, then enter ESPERA.
REQ-022 In ESPERA, the block SHALL wait GAP_CICLOS cycles with insere=0 and numero held, then advance the index.
REQ-023 After the last index (NUM_DIGITOS-1) has been strobed, the block SHALL send one extra closing insere with numero=buf[NUM_DIGITOS-1] in FECHA, followed by GAP_CICLOS idle cycles.
REQ-024 In FIM, the block SHALL pulse fim_jogo for 1 cycle with numero=buf[NUM_DIGITOS-1], then return to COLETA with qtd_digitos=0.
REQ-025 Timing: if confirma is accepted at edge t, strobes SHALL occur at t+1+k*(GAP_CICLOS+1) for k=0..NUM_DIGITOS, and fim_jogo SHALL occur at t+1+(NUM_DIGITOS+1)*(GAP_CICLOS+1).
REQ-026 ocupado SHALL be high from t+1 through the fim_jogo cycle inclusive.
REQ-027 While ocupado is high, digito_valido, apaga and confirma SHALL be ignored, with no erro.
REQ-028 insere and fim_jogo SHALL never be high in the same cycle.
REQ-029 numero SHALL be 0 whenever the block is in COLETA.

Reset
REQ-030 reset SHALL set the state to COLETA and drive qtd_digitos=0, numero=0, insere=0, fim_jogo=0, ocupado=0 and erro=0 on the next edge.
REQ-031 reset SHALL clear the buffer to all zeros.
REQ-032 reset asserted mid-send SHALL abort the send, and no further insere or fim_jogo SHALL be produced.

Configuration
REQ-033 With APOSTA_CONTADOR_EN defined, the block SHALL add output apostas[4:0], incremented in the fim_jogo cycle, saturating at 31, and cleared by reset.
REQ-034 Without APOSTA_CONTADOR_EN, port apostas and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-035 Package loteria_pkg SHALL hold the state enum, DIGITO_W=4, DIGITO_MAX=9 and the 5-bit counter width shared with the prize outputs.
REQ-036 Sub-module aposta_buffer SHALL implement the NUM_DIGITOS x 4-bit register file with write pointer and clear; the top level SHALL contain the FSM and the timing logic.

Verification
REQ-037 Enter 5,3,8,2,0 and confirma (GAP=1) -> insere with numero 5,3,8,2,0,0 at t+1,+3,+5,+7,+9,+11 and fim_jogo with numero=0 at t+13.
REQ-038 digito_in=12 strobed -> erro pulses once and qtd_digitos is unchanged; a 6th valid digit -> erro and buffer unchanged.
REQ-039 confirma with 3 digits -> erro and no insere; apaga then 5 digits and confirma -> a normal send.
REQ-040 reset at t+6 during a send -> no later insere or fim_jogo, all outputs 0, state COLETA.
REQ-041 digito_valido, apaga and confirma toggled during a send -> output sequence unchanged and no erro.
REQ-042 With APOSTA_CONTADOR_EN, 33 consecutive bets -> apostas saturates at 31.
